// File: rtl/cfg_ldr.sv
// Configuration-word loader: streams words into a shadow bank addressed by cfg_cnt's
// pointer, then commits the whole bank to cfg_out once the datapath is idle.
module cfg_ldr #(
   parameter int DATA_W   = 32,
   parameter int MAX_CNT  = 3,
   parameter int SIZE_PTR = 2
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [DATA_W-1:0]             cfg_data,
   input  logic                          cfg_valid,
   output logic                          cfg_ready,
   output logic                          go,
   input  logic [SIZE_PTR-1:0]           pointer,
   input  logic                          endldcr,
   input  logic                          dp_idle,
   output logic [(MAX_CNT+1)*DATA_W-1:0] cfg_out,
   output logic                          cfg_upd,
   output logic                          busy,
   output logic                          sync_err
);

   localparam int NW = MAX_CNT + 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      WAIT_IDLE = 2'd2
   } state_t;

   state_t                  state_q;
   logic [DATA_W-1:0]       shadow_q [NW];
   logic [NW*DATA_W-1:0]    cfg_out_q;
   logic                    cfg_upd_q;
   logic                    sync_err_q;
   logic                    acc;

   // go is a pure decode of state and cfg_valid, so the pointer feedback never loops back
   assign cfg_ready = (state_q != WAIT_IDLE);
   assign acc       = cfg_valid & cfg_ready;
   assign go        = acc;
   assign busy      = (state_q != IDLE);
   assign cfg_out   = cfg_out_q;
   assign cfg_upd   = cfg_upd_q;
   assign sync_err  = sync_err_q;

   // Frame FSM, shadow bank capture and atomic commit to the active bank
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cfg_out_q  <= {(NW*DATA_W){1'b0}};
         cfg_upd_q  <= 1'b0;
         sync_err_q <= 1'b0;
         for (int k = 0; k < NW; k++) begin
            shadow_q[k] <= {DATA_W{1'b0}};
         end
      end else begin
         cfg_upd_q <= 1'b0;
         if (acc) begin
            for (int k = 0; k < NW; k++) begin
               if (pointer == SIZE_PTR'(k)) begin
                  shadow_q[k] <= cfg_data;
               end
            end
         end
         case (state_q)
            IDLE: begin
               if (acc) begin
                  if (pointer != {SIZE_PTR{1'b0}}) begin
                     sync_err_q <= 1'b1;
                  end
                  state_q <= endldcr ? WAIT_IDLE : LOAD;
               end else begin
                  state_q <= IDLE;
               end
            end
            LOAD: begin
               if (acc && endldcr) begin
                  state_q <= WAIT_IDLE;
               end else begin
                  state_q <= LOAD;
               end
            end
            WAIT_IDLE: begin
               if (dp_idle) begin
                  for (int k = 0; k < NW; k++) begin
                     cfg_out_q[k*DATA_W +: DATA_W] <= shadow_q[k];
                  end
                  cfg_upd_q <= 1'b1;
                  state_q   <= IDLE;
               end else begin
                  state_q <= WAIT_IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cfg_ldr.sv
// Directed bench for cfg_ldr: a behavioural cfg_cnt model drives pointer/endldcr,
// and a second instance covers the single-word (MAX_CNT=0) configuration.
module tb_cfg_ldr;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [31:0]  cfg_data;
   logic         cfg_valid;
   logic         cfg_ready, go;
   logic [1:0]   pointer;
   logic         endldcr;
   logic         dp_idle;
   logic [127:0] cfg_out;
   logic         cfg_upd, busy, sync_err;

   logic [1:0]   cnt_q;
   logic         ld_en;
   logic [1:0]   ld_val;

   logic [31:0]  d1;
   logic         v1, r1, go1, upd1, busy1, err1;
   logic [31:0]  out1;
   logic         ptr1, end1, idle1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // cfg_cnt model with a bench preload for the pointer-sync case
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)   cnt_q <= 2'd0;
      else if (ld_en) cnt_q <= ld_val;
      else if (go)    cnt_q <= (cnt_q == 2'd3) ? 2'd0 : cnt_q + 2'd1;
   end

   assign pointer = cnt_q;
   assign endldcr = (cnt_q == 2'd3);
   assign ptr1    = 1'b0;
   assign end1    = 1'b1;
   assign idle1   = 1'b1;

   cfg_ldr #(.DATA_W(32), .MAX_CNT(3), .SIZE_PTR(2)) u_dut (
      .clk(clk), .reset_n(reset_n), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready), .go(go), .pointer(pointer), .endldcr(endldcr),
      .dp_idle(dp_idle), .cfg_out(cfg_out), .cfg_upd(cfg_upd), .busy(busy),
      .sync_err(sync_err)
   );

   cfg_ldr #(.DATA_W(32), .MAX_CNT(0), .SIZE_PTR(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .cfg_data(d1), .cfg_valid(v1),
      .cfg_ready(r1), .go(go1), .pointer(ptr1), .endldcr(end1),
      .dp_idle(idle1), .cfg_out(out1), .cfg_upd(upd1), .busy(busy1),
      .sync_err(err1)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send_frame(input logic [127:0] f);
      for (int k = 0; k < 4; k++) begin
         cfg_data  = f[k*32 +: 32];
         cfg_valid = 1'b1;
         #1;
         chk("frame go", go, 1'b1);
         tick();
      end
      cfg_valid = 1'b0;
   endtask

   logic [127:0] fa, fc, fd, fe, fb, ff, fg;

   initial begin
      fa = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
      fc = {32'hC3C3_1003, 32'hC2C2_1002, 32'hC1C1_1001, 32'hC0C0_1000};
      fd = {32'hD3D3_2003, 32'hD2D2_2002, 32'hD1D1_2001, 32'hD0D0_2000};
      fe = {32'hE3E3_3003, 32'hE2E2_3002, 32'hE1E1_3001, 32'hE0E0_3000};
      fb = {32'hB3B3_4003, 32'hB2B2_4002, 32'hB1B1_4001, 32'hB0B0_4000};
      ff = {32'hF3F3_5003, 32'hF2F2_5002, 32'hF1F1_5001, 32'hF0F0_5000};
      fg = {32'h6363_6003, 32'h6262_6002, 32'h6161_6001, 32'h6060_6000};

      reset_n = 1'b0; cfg_valid = 1'b0; cfg_data = 32'd0; dp_idle = 1'b1;
      ld_en = 1'b0; ld_val = 2'd0; v1 = 1'b0; d1 = 32'd0;
      #1;
      chk("rst ready", cfg_ready, 1'b1);
      chk("rst go", go, 1'b0);
      chk("rst busy", busy, 1'b0);
      chk("rst out", cfg_out, 128'd0);
      chk("rst upd", cfg_upd, 1'b0);
      chk("rst err", sync_err, 1'b0);
      tick(); tick();
      reset_n = 1'b1;

      // Test 1: back-to-back frame with valid held, immediate commit
      for (int k = 0; k < 4; k++) begin
         cfg_data  = fa[k*32 +: 32];
         cfg_valid = 1'b1;
         #1;
         chk("t1 go", go, 1'b1);
         chk("t1 upd early", cfg_upd, 1'b0);
         tick();
      end
      #1;
      chk("t1 go held", go, 1'b0);
      chk("t1 ready wait", cfg_ready, 1'b0);
      chk("t1 out pre", cfg_out, 128'd0);
      chk("t1 busy", busy, 1'b1);
      tick();
      cfg_valid = 1'b0;
      chk("t1 upd", cfg_upd, 1'b1);
      chk("t1 out", cfg_out, fa);
      chk("t1 ptr", pointer, 2'd0);
      tick();
      chk("t1 upd fall", cfg_upd, 1'b0);
      chk("t1 busy idle", busy, 1'b0);

      // Test 2: datapath busy holds the commit
      dp_idle = 1'b0;
      send_frame(fc);
      for (int i = 0; i < 10; i++) begin
         chk("t2 ready", cfg_ready, 1'b0);
         chk("t2 busy", busy, 1'b1);
         chk("t2 out hold", cfg_out, fa);
         chk("t2 upd", cfg_upd, 1'b0);
         tick();
      end
      dp_idle = 1'b1;
      tick();
      chk("t2 upd", cfg_upd, 1'b1);
      chk("t2 out", cfg_out, fc);
      tick();
      chk("t2 upd fall", cfg_upd, 1'b0);

      // Test 3: valid toggling every cycle
      begin
         int idx;
         idx = 0;
         for (int c = 0; c < 8; c++) begin
            cfg_valid = (c % 2 == 0);
            if (cfg_valid) cfg_data = fd[idx*32 +: 32];
            #1;
            chk("t3 go", go, cfg_valid);
            chk("t3 no commit", cfg_upd, 1'b0);
            chk("t3 out hold", cfg_out, fc);
            tick();
            if (c % 2 == 0) idx++;
         end
         cfg_valid = 1'b0;
         chk("t3 upd", cfg_upd, 1'b1);
         chk("t3 out", cfg_out, fd);
         tick();
      end

      // Test 4: reset mid-frame clears everything, next frame still works
      for (int k = 0; k < 2; k++) begin
         cfg_data = fe[k*32 +: 32]; cfg_valid = 1'b1;
         tick();
      end
      cfg_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("t4 out clr", cfg_out, 128'd0);
      chk("t4 ptr", pointer, 2'd0);
      chk("t4 busy", busy, 1'b0);
      tick();
      chk("t4 upd", cfg_upd, 1'b0);
      tick();
      reset_n = 1'b1;
      chk("t4 upd rel", cfg_upd, 1'b0);
      send_frame(fb);
      tick();
      chk("t4 upd B", cfg_upd, 1'b1);
      chk("t4 out B", cfg_out, fb);
      tick();

      // Test 5: frame begins at pointer 2, untouched slots keep old words
      ld_en = 1'b1; ld_val = 2'd2;
      tick();
      ld_en = 1'b0;
      chk("t5 ptr", pointer, 2'd2);
      chk("t5 err pre", sync_err, 1'b0);
      for (int k = 2; k < 4; k++) begin
         cfg_data = ff[k*32 +: 32]; cfg_valid = 1'b1;
         tick();
         chk("t5 err", sync_err, 1'b1);
      end
      cfg_valid = 1'b0;
      tick();
      chk("t5 upd", cfg_upd, 1'b1);
      chk("t5 out", cfg_out, {ff[127:64], fb[63:0]});
      tick();
      send_frame(fg);
      tick();
      chk("t5 out G", cfg_out, fg);
      chk("t5 err sticky", sync_err, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("t5 err clr", sync_err, 1'b0);
      tick();
      reset_n = 1'b1;

      // Test 6: single-word bank commits once per word
      for (int w = 0; w < 3; w++) begin
         d1 = 32'h5A00_0000 + 32'(w) * 32'h0001_0101;
         v1 = 1'b1;
         #1;
         chk("t6 go", go1, 1'b1);
         tick();
         v1 = 1'b0;
         chk("t6 ready", r1, 1'b0);
         chk("t6 upd early", upd1, 1'b0);
         tick();
         chk("t6 upd", upd1, 1'b1);
         chk("t6 out", out1, 32'h5A00_0000 + 32'(w) * 32'h0001_0101);
         tick();
         chk("t6 upd fall", upd1, 1'b0);
      end
      chk("t6 err", err1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
